mem_wb_writer: RTL and testbench

MEM→WB pipeline register and register-file write driver for the five-stage MIPS core. Captures the MEM-stage instruction and data-SRAM read data, and performs load byte/halfword select and sign/zero extension. Drives the regfile's `we`/`waddr`/`wdata` write port and a same-cycle forwarding bus back to ID. Also keeps a retired-instruction counter.

---
 rtl/mem_wb_writer.sv | 138 +++++++++++++
 tb/tb_mem_wb_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writer.sv
// mem_wb_writer: MEM->WB pipeline register and regfile write driver.
// Extends load data in the MEM cycle, captures the final write data into the
// WB register, drives the regfile write port, the ID bypass bus, and counts
// retired instructions.
// Optional trace port: define MEM_WB_DEBUG_EN to drive debug_* from WB state;
// otherwise the debug_* ports are tied to zero.
module mem_wb_writer #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                mem_valid,
  input  logic                mem_we,
  input  logic [4:0]          mem_waddr,
  input  logic [31:0]         mem_result,
  input  logic [2:0]          mem_load_type,
  input  logic [1:0]          mem_addr_lo,
  input  logic [31:0]         mem_pc,
  input  logic [31:0]         data_sram_rdata,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic                fwd_we,
  output logic [4:0]          fwd_waddr,
  output logic [31:0]         fwd_wdata,
  output logic [31:0]         wb_pc,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;
  localparam logic [2:0] LT_LW  = 3'b101;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc;
  } wb_reg_t;

  wb_reg_t         wb_q;
  wb_reg_t         wb_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  // Lane select and sign/zero extension of the load data (MEM cycle)
  always_comb begin
    byte_sel  = data_sram_rdata[7:0];
    half_sel  = data_sram_rdata[15:0];
    load_data = mem_result;
    case (mem_addr_lo)
      2'd0:    byte_sel = data_sram_rdata[7:0];
      2'd1:    byte_sel = data_sram_rdata[15:8];
      2'd2:    byte_sel = data_sram_rdata[23:16];
      default: byte_sel = data_sram_rdata[31:24];
    endcase
    // addr_lo[0] is ignored for halfwords; misalignment faults upstream
    if (mem_addr_lo[1]) begin
      half_sel = data_sram_rdata[31:16];
    end
    case (mem_load_type)
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h000000, byte_sel};
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'h0000, half_sel};
      LT_LW:   load_data = data_sram_rdata;
      default: load_data = mem_result;
    endcase
  end

  // Next WB register contents: bubble on stall or flush
  always_comb begin
    wb_d = '0;
    if (!(stall || flush)) begin
      wb_d.valid = mem_valid;
      wb_d.we    = mem_we;
      wb_d.waddr = mem_waddr;
      wb_d.wdata = load_data;
      wb_d.pc    = mem_pc;
    end
  end

  // WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  // Retired-instruction counter; counts every valid WB instruction, wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (wb_q.valid) begin
      retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  // Regfile write port; writes to $0 are never issued
  assign rf_we    = wb_q.valid & wb_q.we & (wb_q.waddr != '0);
  assign rf_waddr = wb_q.waddr;
  assign rf_wdata = wb_q.wdata;
  assign wb_pc    = wb_q.pc;

  // Same-cycle bypass to ID
  assign fwd_we    = rf_we;
  assign fwd_waddr = rf_waddr;
  assign fwd_wdata = rf_wdata;

`ifdef MEM_WB_DEBUG_EN
  // Trace port mirrors the WB write
  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writer.sv
// Scoreboard bench for mem_wb_writer: the driver predicts each WB slot from a
// behavioural model and queues it; the monitor compares after each edge.
module tb_mem_wb_writer;

  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          mem_valid = 1'b0;
  logic          mem_we = 1'b0;
  logic [4:0]    mem_waddr = '0;
  logic [31:0]   mem_result = '0;
  logic [2:0]    mem_load_type = '0;
  logic [1:0]    mem_addr_lo = '0;
  logic [31:0]   mem_pc = '0;
  logic [31:0]   data_sram_rdata = '0;
  logic          rf_we, fwd_we;
  logic [4:0]    rf_waddr, fwd_waddr;
  logic [31:0]   rf_wdata, fwd_wdata, wb_pc;
  logic [CW-1:0] retire_cnt;
  logic [31:0]   debug_wb_pc;
  logic [3:0]    debug_wb_rf_wen;
  logic [4:0]    debug_wb_rf_wnum;
  logic [31:0]   debug_wb_rf_wdata;

  mem_wb_writer #(.RETIRE_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_result(mem_result), .mem_load_type(mem_load_type),
    .mem_addr_lo(mem_addr_lo), .mem_pc(mem_pc),
    .data_sram_rdata(data_sram_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .wb_pc(wb_pc), .retire_cnt(retire_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned m_cnt = 0;
  bit          m_wb_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected regfile write data from the load rules, in plain arithmetic
  function automatic logic [31:0] model_wdata(input int unsigned lt, input int unsigned lo,
                                              input logic [31:0] result, input logic [31:0] rdata);
    int unsigned b, h, r;
    r = rdata;
    b = (r >> (8 * lo)) % 256;
    h = (r >> (16 * (lo / 2))) % 65536;
    case (lt)
      1:       return (b >= 128) ? 32'(b - 256) : 32'(b);
      2:       return 32'(b);
      3:       return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      4:       return 32'(h);
      5:       return rdata;
      default: return result;
    endcase
  endfunction

  // Drive one MEM-stage cycle and queue the WB slot it should produce
  task automatic drive(input bit r, input bit s, input bit f, input bit v, input bit we,
                       input logic [4:0] wa, input logic [31:0] res, input logic [2:0] lt,
                       input logic [1:0] lo, input logic [31:0] pc, input logic [31:0] rd);
    exp_t e;
    bit   bub;
    @(negedge clk);
    rst = r; stall = s; flush = f; mem_valid = v; mem_we = we; mem_waddr = wa;
    mem_result = res; mem_load_type = lt; mem_addr_lo = lo; mem_pc = pc;
    data_sram_rdata = rd;
    if (r) m_cnt = 0;
    else if (m_wb_valid) m_cnt = (m_cnt + 1) % CNT_MOD;
    bub     = r || s || f;
    e.we    = !bub && v && we && (wa != 0);
    e.waddr = bub ? 5'd0 : wa;
    e.wdata = bub ? 32'd0 : model_wdata(int'(lt), int'(lo), res, rd);
    e.pc    = bub ? 32'd0 : pc;
    e.cnt   = m_cnt;
    m_wb_valid = !bub && v;
    sb.push_back(e);
  endtask

  // Monitor: compare the WB outputs against the queued prediction after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rf_we",      32'(rf_we),      32'(e.we));
        chk("rf_waddr",   32'(rf_waddr),   32'(e.waddr));
        chk("rf_wdata",   rf_wdata,        e.wdata);
        chk("fwd_we",     32'(fwd_we),     32'(e.we));
        chk("fwd_waddr",  32'(fwd_waddr),  32'(e.waddr));
        chk("fwd_wdata",  fwd_wdata,       e.wdata);
        chk("wb_pc",      wb_pc,           e.pc);
        chk("retire_cnt", 32'(retire_cnt), 32'(e.cnt));
`ifdef MEM_WB_DEBUG_EN
        chk("debug_pc",    debug_wb_pc,              e.pc);
        chk("debug_wen",   32'(debug_wb_rf_wen),     e.we ? 32'hF : 32'h0);
        chk("debug_wnum",  32'(debug_wb_rf_wnum),    32'(e.waddr));
        chk("debug_wdata", debug_wb_rf_wdata,        e.wdata);
`else
        chk("debug_pc",    debug_wb_pc,              32'd0);
        chk("debug_wen",   32'(debug_wb_rf_wen),     32'd0);
        chk("debug_wnum",  32'(debug_wb_rf_wnum),    32'd0);
        chk("debug_wdata", debug_wb_rf_wdata,        32'd0);
`endif
      end
    end
  end

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    int wait_cycles;
    // reset held two cycles with a valid write presented
    drive(1, 0, 0, 1, 1, 5'd5, 32'h1111_1111, 3'd0, 2'd0, 32'h0000_0100, RD);
    drive(1, 0, 0, 1, 1, 5'd5, 32'h1111_1111, 3'd0, 2'd0, 32'h0000_0104, RD);
    // ALU write
    drive(0, 0, 0, 1, 1, 5'd8, 32'h1234_5678, 3'd0, 2'd0, 32'h0000_0200, RD);
    // load extension
    drive(0, 0, 0, 1, 1, 5'd9,  32'hAAAA_AAAA, 3'd1, 2'd3, 32'h0000_0204, RD);
    drive(0, 0, 0, 1, 1, 5'd10, 32'hAAAA_AAAA, 3'd2, 2'd3, 32'h0000_0208, RD);
    drive(0, 0, 0, 1, 1, 5'd11, 32'hAAAA_AAAA, 3'd1, 2'd1, 32'h0000_020C, RD);
    drive(0, 0, 0, 1, 1, 5'd12, 32'hAAAA_AAAA, 3'd3, 2'd2, 32'h0000_0210, RD);
    drive(0, 0, 0, 1, 1, 5'd13, 32'hAAAA_AAAA, 3'd4, 2'd0, 32'h0000_0214, RD);
    drive(0, 0, 0, 1, 1, 5'd14, 32'hAAAA_AAAA, 3'd5, 2'd2, 32'h0000_0218, RD);
    drive(0, 0, 0, 1, 1, 5'd15, 32'hAAAA_AAAA, 3'd6, 2'd1, 32'h0000_021C, RD);
    // $0 guard and invalid-with-we
    drive(0, 0, 0, 1, 1, 5'd0,  32'hDEAD_BEEF, 3'd0, 2'd0, 32'h0000_0220, RD);
    drive(0, 0, 0, 0, 1, 5'd3,  32'h0BAD_0BAD, 3'd0, 2'd0, 32'h0000_0224, RD);
    // stall, flush, both
    drive(0, 0, 0, 1, 1, 5'd16, 32'h0000_0010, 3'd0, 2'd0, 32'h0000_0300, RD);
    drive(0, 1, 0, 1, 1, 5'd17, 32'h0000_0011, 3'd0, 2'd0, 32'h0000_0304, RD);
    drive(0, 0, 1, 1, 1, 5'd18, 32'h0000_0012, 3'd0, 2'd0, 32'h0000_0308, RD);
    drive(0, 1, 1, 1, 1, 5'd19, 32'h0000_0013, 3'd0, 2'd0, 32'h0000_030C, RD);
    drive(0, 0, 0, 1, 1, 5'd20, 32'h0000_0014, 3'd0, 2'd0, 32'h0000_0310, RD);
    // counter wrap: reset, 17 valid instructions, then drain
    drive(1, 0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, RD);
    for (int i = 0; i < 17; i++)
      drive(0, 0, 0, 1, i[0], 5'(i + 1), 32'(i * 7), 3'd0, 2'd0, 32'h400 + 32'(4 * i), RD);
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, RD);
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, RD);
    // mid-stream reset discards the in-flight instruction
    drive(0, 0, 0, 1, 1, 5'd21, 32'h5555_0000, 3'd0, 2'd0, 32'h0000_0500, RD);
    drive(1, 0, 0, 1, 1, 5'd22, 32'h5555_0001, 3'd0, 2'd0, 32'h0000_0504, RD);
    drive(0, 0, 0, 1, 1, 5'd23, 32'h5555_0002, 3'd0, 2'd0, 32'h0000_0508, RD);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(39) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0,
            $urandom_range(3) != 0, $urandom_range(3) != 0, 5'($urandom),
            $urandom, 3'($urandom), 2'($urandom), $urandom, $urandom);
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, RD);
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
